mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_rr_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, client request record and payload helpers for the two-client
// memory arbiter.
package mem_arbiter_pkg;

    localparam int RW        = 16;
    localparam int WB_ADDR_W = 16;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [RW-1:0]        data;
    } client_req_t;

    // Write data travels downstream only on writes; reads present zero.
    function automatic client_req_t latch_req(input client_req_t req);
        client_req_t r;
        r      = req;
        r.data = req.we ? req.data : {RW{1'b0}};
        return r;
    endfunction

    // Read data travels upstream only on reads; writes return zero.
    function automatic logic [RW-1:0] rd_payload(input logic we, input logic [RW-1:0] d);
        return we ? {RW{1'b0}} : d;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of client-side and master-side signals around the arbiter.
// The slave modport is the arbiter's view and the master modport is the environment's.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                 i_c0_req;
    logic                 i_c0_we;
    logic [WB_ADDR_W-1:0] i_c0_addr;
    logic [RW-1:0]        i_c0_data;
    logic [RW-1:0]        o_c0_data;
    logic                 o_c0_ack;

    logic                 i_c1_req;
    logic                 i_c1_we;
    logic [WB_ADDR_W-1:0] i_c1_addr;
    logic [RW-1:0]        i_c1_data;
    logic [RW-1:0]        o_c1_data;
    logic                 o_c1_ack;

    logic                 o_mem_req;
    logic                 o_mem_we;
    logic [WB_ADDR_W-1:0] o_mem_addr;
    logic [RW-1:0]        o_mem_data;
    logic [RW-1:0]        i_mem_data;
    logic                 i_mem_ack;
    logic                 o_mem_next;

    modport slave (
        input  i_c0_req, i_c0_we, i_c0_addr, i_c0_data,
        output o_c0_data, o_c0_ack,
        input  i_c1_req, i_c1_we, i_c1_addr, i_c1_data,
        output o_c1_data, o_c1_ack,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_data, o_mem_next,
        input  i_mem_data, i_mem_ack
    );

    modport master (
        output i_c0_req, i_c0_we, i_c0_addr, i_c0_data,
        input  o_c0_data, o_c0_ack,
        output i_c1_req, i_c1_we, i_c1_addr, i_c1_data,
        input  o_c1_data, o_c1_ack,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_data, o_mem_next,
        output i_mem_data, i_mem_ack
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone eligible client wins,
// and on a tie the client that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] elig_i,
    input  logic       last_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    // Grant selection from eligibility and the previous winner.
    always_comb begin
        gnt_valid_o = |elig_i;
        gnt_idx_o   = 1'b0;
        case (elig_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = ~last_i;
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the instruction-fetch client (0) and data client (1) onto the single
// request port of wishbone_master, one access in flight, registered outputs.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              mem_req_q, mem_req_d;
    client_req_t       mem_q, mem_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0][RW-1:0] cdata_q, cdata_d;

    logic [1:0]        elig_s;
    logic              gnt_valid_s;
    logic              gnt_idx_s;
    client_req_t       c0_req_s, c1_req_s, sel_req_s;

    // A client is not eligible during the cycle its own ack is being shown.
    assign elig_s   = {bus.i_c1_req & ~ack_q[1], bus.i_c0_req & ~ack_q[0]};
    assign c0_req_s = '{we: bus.i_c0_we, addr: bus.i_c0_addr, data: bus.i_c0_data};
    assign c1_req_s = '{we: bus.i_c1_we, addr: bus.i_c1_addr, data: bus.i_c1_data};
    assign sel_req_s = gnt_idx_s ? c1_req_s : c0_req_s;

    rr_pick2 u_pick (
        .elig_i      (elig_s),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid_s),
        .gnt_idx_o   (gnt_idx_s)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            mem_req_q <= 1'b0;
            mem_q     <= '{we: 1'b0, addr: {WB_ADDR_W{1'b0}}, data: {RW{1'b0}}};
            ack_q     <= 2'b00;
            cdata_q   <= {2{ {RW{1'b0}} }};
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            mem_req_q <= mem_req_d;
            mem_q     <= mem_d;
            ack_q     <= ack_d;
            cdata_q   <= cdata_d;
        end
    end

    // Next-state: a grant enters BUSY, the master's ack returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.i_mem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; a spurious ack in IDLE falls through to hold.
    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        mem_req_d = mem_req_q;
        mem_d     = mem_q;
        ack_d     = 2'b00;
        cdata_d   = cdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    owner_d   = gnt_idx_s;
                    last_d    = gnt_idx_s;
                    mem_req_d = 1'b1;
                    mem_d     = latch_req(sel_req_s);
                end else begin
                    mem_req_d = mem_req_q;
                end
            end
            ST_BUSY: begin
                if (bus.i_mem_ack) begin
                    mem_req_d        = 1'b0;
                    ack_d[owner_q]   = 1'b1;
                    cdata_d[owner_q] = rd_payload(mem_q.we, bus.i_mem_data);
                end else begin
                    mem_req_d = mem_req_q;
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign bus.o_mem_req  = mem_req_q;
    assign bus.o_mem_we   = mem_q.we;
    assign bus.o_mem_addr = mem_q.addr;
    assign bus.o_mem_data = mem_q.data;
    assign bus.o_mem_next = 1'b0;
    assign bus.o_c0_ack   = ack_q[0];
    assign bus.o_c1_ack   = ack_q[1];
    assign bus.o_c0_data  = cdata_q[0];
    assign bus.o_c1_data  = cdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized
// traffic, compared against a transaction-level reference model every cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: "is an access in flight, whose, what was asked for".
    typedef struct {
        bit                   active;
        int                   client;
        bit                   we;
        bit [WB_ADDR_W-1:0]   addr;
        bit [RW-1:0]          wdata;
    } access_t;

    access_t              cur;
    int                   most_recent;   // client served most recently
    bit [1:0]             e_ack;
    bit [RW-1:0]          e_cdata [2];
    bit [WB_ADDR_W-1:0]   e_addr;
    bit [RW-1:0]          e_mdata;
    bit                   e_we;
    bit                   e_req;

    task automatic model_reset();
        cur         = '{active: 1'b0, client: 0, we: 1'b0, addr: '0, wdata: '0};
        most_recent = 1;
        e_ack       = 2'b00;
        e_cdata[0]  = '0;
        e_cdata[1]  = '0;
        e_addr      = '0;
        e_mdata     = '0;
        e_we        = 1'b0;
        e_req       = 1'b0;
    endtask

    function automatic bit wants(int k);
        bit r;
        r = (k == 0) ? bus.i_c0_req : bus.i_c1_req;
        return r && !e_ack[k];
    endfunction

    // One clock of the model, evaluated from the inputs present at the edge.
    task automatic model_step();
        bit [1:0] next_ack;
        int       pick;
        next_ack = 2'b00;
        if (i_rst) begin
            model_reset();
            return;
        end
        if (cur.active) begin
            if (bus.i_mem_ack) begin
                next_ack[cur.client]  = 1'b1;
                e_cdata[cur.client]   = cur.we ? '0 : bus.i_mem_data;
                cur.active            = 1'b0;
                e_req                 = 1'b0;
            end
        end else if (wants(0) || wants(1)) begin
            if (wants(0) && wants(1)) pick = 1 - most_recent;
            else                      pick = wants(1) ? 1 : 0;
            cur.active = 1'b1;
            cur.client = pick;
            cur.we     = (pick == 0) ? bus.i_c0_we   : bus.i_c1_we;
            cur.addr   = (pick == 0) ? bus.i_c0_addr : bus.i_c1_addr;
            cur.wdata  = (pick == 0) ? bus.i_c0_data : bus.i_c1_data;
            most_recent = pick;
            e_req   = 1'b1;
            e_we    = cur.we;
            e_addr  = cur.addr;
            e_mdata = cur.we ? cur.wdata : '0;
        end
        e_ack = next_ack;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("mem_req",  32'(bus.o_mem_req),  32'(e_req));
        chk("mem_we",   32'(bus.o_mem_we),   32'(e_we));
        chk("mem_addr", 32'(bus.o_mem_addr), 32'(e_addr));
        chk("mem_data", 32'(bus.o_mem_data), 32'(e_mdata));
        chk("c0_ack",   32'(bus.o_c0_ack),   32'(e_ack[0]));
        chk("c1_ack",   32'(bus.o_c1_ack),   32'(e_ack[1]));
        chk("c0_data",  32'(bus.o_c0_data),  32'(e_cdata[0]));
        chk("c1_data",  32'(bus.o_c1_data),  32'(e_cdata[1]));
        chk("mem_next", 32'(bus.o_mem_next), 32'd0);
    endtask

    task automatic step();
        @(posedge i_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_client(input int k, input logic req, input logic we,
                              input logic [WB_ADDR_W-1:0] addr, input logic [RW-1:0] data);
        if (k == 0) begin
            bus.i_c0_req = req; bus.i_c0_we = we; bus.i_c0_addr = addr; bus.i_c0_data = data;
        end else begin
            bus.i_c1_req = req; bus.i_c1_we = we; bus.i_c1_addr = addr; bus.i_c1_data = data;
        end
    endtask

    logic [WB_ADDR_W-1:0] rise_addr [$];
    logic                 prev_req;
    bit                   creq [2];

    initial begin
        set_client(0, 1'b0, 1'b0, '0, '0);
        set_client(1, 1'b0, 1'b0, '0, '0);
        bus.i_mem_ack  = 1'b0;
        bus.i_mem_data = '0;
        model_reset();

        // Reset state
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        chk("rst_mem_req", 32'(bus.o_mem_req), 32'd0);

        // Single read from client 0, master answers three cycles later
        set_client(0, 1'b1, 1'b0, 16'h0010, 16'h5555);
        step();
        chk("rd_req_rise", 32'(bus.o_mem_req), 32'd1);
        chk("rd_addr", 32'(bus.o_mem_addr), 32'h0010);
        chk("rd_wdata_zero", 32'(bus.o_mem_data), 32'd0);
        step();
        step();
        bus.i_mem_ack  = 1'b1;
        bus.i_mem_data = 16'hBEEF;
        step();
        chk("rd_ack", 32'(bus.o_c0_ack), 32'd1);
        chk("rd_data", 32'(bus.o_c0_data), 32'hBEEF);
        chk("rd_c1_ack", 32'(bus.o_c1_ack), 32'd0);
        chk("rd_req_fall", 32'(bus.o_mem_req), 32'd0);
        bus.i_mem_ack = 1'b0;
        set_client(0, 1'b0, 1'b0, '0, '0);
        step();
        chk("rd_ack_one_cycle", 32'(bus.o_c0_ack), 32'd0);

        // Spurious ack while idle
        bus.i_mem_ack  = 1'b1;
        bus.i_mem_data = 16'hA5A5;
        step();
        bus.i_mem_ack = 1'b0;
        chk("spur_c0_ack", 32'(bus.o_c0_ack), 32'd0);
        chk("spur_c1_ack", 32'(bus.o_c1_ack), 32'd0);
        chk("spur_req", 32'(bus.o_mem_req), 32'd0);

        // Write from client 1 with client inputs churning during BUSY
        set_client(1, 1'b1, 1'b1, 16'h0200, 16'h1234);
        step();
        for (int i = 0; i < 4; i++) begin
            set_client(1, 1'b1, 1'($urandom), WB_ADDR_W'($urandom), RW'($urandom));
            set_client(0, 1'($urandom), 1'($urandom), WB_ADDR_W'($urandom), RW'($urandom));
            step();
            chk("wr_we_held", 32'(bus.o_mem_we), 32'd1);
            chk("wr_addr_held", 32'(bus.o_mem_addr), 32'h0200);
            chk("wr_data_held", 32'(bus.o_mem_data), 32'h1234);
        end
        set_client(0, 1'b0, 1'b0, '0, '0);
        bus.i_mem_ack  = 1'b1;
        bus.i_mem_data = 16'hFFFF;
        step();
        bus.i_mem_ack = 1'b0;
        chk("wr_c1_ack", 32'(bus.o_c1_ack), 32'd1);
        chk("wr_c1_data_zero", 32'(bus.o_c1_data), 32'd0);
        chk("wr_c0_data_held", 32'(bus.o_c0_data), 32'hBEEF);
        set_client(1, 1'b0, 1'b0, '0, '0);
        step();

        // Reset in the middle of a client 0 read
        set_client(0, 1'b1, 1'b0, 16'h0044, 16'h0000);
        step();
        step();
        set_client(0, 1'b0, 1'b0, '0, '0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("mid_rst_req", 32'(bus.o_mem_req), 32'd0);
        chk("mid_rst_c0_data", 32'(bus.o_c0_data), 32'd0);
        chk("mid_rst_c1_data", 32'(bus.o_c1_data), 32'd0);
        set_client(0, 1'b1, 1'b0, 16'h0048, 16'h0000);
        step();
        chk("post_rst_grant", 32'(bus.o_mem_req), 32'd1);
        bus.i_mem_ack = 1'b1;
        step();
        bus.i_mem_ack = 1'b0;
        set_client(0, 1'b0, 1'b0, '0, '0);
        step();

        // Tie after reset: both clients request continuously
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        set_client(0, 1'b1, 1'b0, 16'h0AAA, 16'h0000);
        set_client(1, 1'b1, 1'b0, 16'h0BBB, 16'h0000);
        prev_req = 1'b0;
        for (int i = 0; i < 40 && rise_addr.size() < 4; i++) begin
            bus.i_mem_ack  = e_req;
            bus.i_mem_data = RW'($urandom);
            step();
            if (bus.o_mem_req && !prev_req) rise_addr.push_back(bus.o_mem_addr);
            prev_req = bus.o_mem_req;
        end
        bus.i_mem_ack = 1'b0;
        chk("tie_grant_count", 32'(rise_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [WB_ADDR_W-1:0] want;
            want = (i % 2 == 0) ? 16'h0AAA : 16'h0BBB;
            if (i < rise_addr.size()) chk("tie_order", 32'(rise_addr[i]), 32'(want));
        end
        set_client(0, 1'b0, 1'b0, '0, '0);
        set_client(1, 1'b0, 1'b0, '0, '0);
        bus.i_mem_ack = e_req;
        step();
        bus.i_mem_ack = 1'b0;
        step();

        // Randomized traffic with latency, spurious acks and rare resets
        creq[0] = 1'b0;
        creq[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_rst          = ($urandom_range(0, 299) == 0);
            bus.i_mem_ack  = e_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            bus.i_mem_data = RW'($urandom);
            for (int k = 0; k < 2; k++) begin
                if (!creq[k]) begin
                    if ($urandom_range(0, 2) == 0) creq[k] = 1'b1;
                end else if (e_ack[k]) begin
                    creq[k] = 1'($urandom_range(0, 1));
                end
                set_client(k, creq[k], 1'($urandom), WB_ADDR_W'($urandom), RW'($urandom));
            end
            step();
        end
        i_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
